// File: rtl/memory_responder.sv
// CPU-side RAM bus slave: a word RAM plus an I/O page at 0xFF00-0xFFFF holding
// an output FIFO with a valid/ready drain port, its status word and a cycle counter.
module memory_responder #(
  parameter int ADDR_BITS  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ram_address_in,
  input  logic [15:0] ram_data_in,
  output logic [15:0] ram_data_out,
  input  logic        ram_read_en,
  input  logic        ram_write_en,
  output logic [15:0] io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [15:0]          mem      [0:(1<<ADDR_BITS)-1];
  logic [15:0]          fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic [15:0]          cycle_count;

  logic                 io_sel;
  logic [ADDR_BITS-1:0] ram_index;
  logic                 read_op;
  logic                 push;
  logic                 push_accept;
  logic                 pop;
  logic                 ovf_clear;
  logic                 full;
  logic                 empty;
  logic [15:0]          status_word;
  logic [15:0]          io_read_value;

  always_comb begin
    io_sel      = (ram_address_in[15:8] == 8'hFF);
    ram_index   = ram_address_in[ADDR_BITS-1:0];
    full        = (count == FULL_COUNT);
    empty       = (count == '0);
    // A simultaneous write wins; the read is dropped and the output holds.
    read_op     = ram_read_en && !ram_write_en;
    push        = ram_write_en && io_sel && (ram_address_in[7:0] == 8'h00);
    ovf_clear   = ram_write_en && io_sel && (ram_address_in[7:0] == 8'h01) && ram_data_in[15];
    pop         = !empty && io_ready;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    push_accept = push && (!full || pop);
    status_word = {overflow, full, empty, 5'b00000, 8'(count)};
    case (ram_address_in[7:0])
      8'h01:   io_read_value = status_word;
      8'h02:   io_read_value = cycle_count;
      default: io_read_value = 16'h0000;
    endcase
  end

  assign io_valid = !empty;
  assign io_data  = empty ? 16'h0000 : fifo_mem[rd_ptr];

  // Storage arrays carry no reset; reset only suppresses the write strobe.
  always_ff @(posedge clk) begin
    if (!rst && ram_write_en && !io_sel) begin
      mem[ram_index] <= ram_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_accept) begin
      fifo_mem[wr_ptr] <= ram_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_data_out <= 16'h0000;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      cycle_count  <= 16'h0000;
    end else begin
      cycle_count <= cycle_count + 16'h0001;

      if (read_op) begin
        ram_data_out <= io_sel ? io_read_value : mem[ram_index];
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      case ({push_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed plus randomized bench for memory_responder, checked against a
// queue-based model of the RAM, the I/O page and the output FIFO.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_address_in;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [15:0] io_data;
  logic        io_valid;
  logic        io_ready;

  memory_responder #(.ADDR_BITS(12), .FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ram_address_in(ram_address_in),
    .ram_data_in   (ram_data_in),
    .ram_data_out  (ram_data_out),
    .ram_read_en   (ram_read_en),
    .ram_write_en  (ram_write_en),
    .io_data       (io_data),
    .io_valid      (io_valid),
    .io_ready      (io_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] mdl_mem [0:4095];
  logic [15:0] mq[$];
  logic        mdl_ovf;
  logic [15:0] mdl_cyc;
  logic [15:0] mdl_out;

  int checks   = 0;
  int failures = 0;

  function automatic logic [15:0] mdl_status();
    return {mdl_ovf, (mq.size() == 8), (mq.size() == 0), 5'b00000, 8'(mq.size())};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    logic is_io;
    logic do_pop;
    logic was_full;
    logic [15:0] rd_val;
    if (rst) begin
      mdl_out = 16'h0000;
      mq.delete();
      mdl_ovf = 1'b0;
      mdl_cyc = 16'h0000;
      return;
    end
    is_io    = (ram_address_in[15:8] == 8'hFF);
    do_pop   = (mq.size() != 0) && io_ready;
    was_full = (mq.size() == 8);
    if (ram_read_en && !ram_write_en) begin
      if (is_io) begin
        if (ram_address_in[7:0] == 8'h01)      rd_val = mdl_status();
        else if (ram_address_in[7:0] == 8'h02) rd_val = mdl_cyc;
        else                                   rd_val = 16'h0000;
      end else begin
        rd_val = mdl_mem[ram_address_in[11:0]];
      end
      mdl_out = rd_val;
    end
    if (do_pop) void'(mq.pop_front());
    if (ram_write_en) begin
      if (!is_io) begin
        mdl_mem[ram_address_in[11:0]] = ram_data_in;
      end else if (ram_address_in[7:0] == 8'h00) begin
        if (was_full && !do_pop) mdl_ovf = 1'b1;
        else                     mq.push_back(ram_data_in);
      end else if (ram_address_in[7:0] == 8'h01 && ram_data_in[15]) begin
        mdl_ovf = 1'b0;
      end
    end
    mdl_cyc = mdl_cyc + 16'h0001;
  endtask

  task automatic checkOutput();
    chk("ram_data_out", ram_data_out, mdl_out);
    chk("io_valid", {15'b0, io_valid}, {15'b0, (mq.size() != 0)});
    chk("io_data", io_data, (mq.size() != 0) ? mq[0] : 16'h0000);
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] d,
                               input logic re, input logic we, input logic rdy);
    rst            = r;
    ram_address_in = a;
    ram_data_in    = d;
    ram_read_en    = re;
    ram_write_en   = we;
    io_ready       = rdy;
    @(posedge clk);
    model_edge();
    #1;
    checkOutput();
  endtask

  task automatic idle_step(input logic rdy);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, rdy);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b0, a, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    applyStimulus(1'b0, a, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  // Quiet cycles with no strobes and no drain; only the counter moves.
  task automatic idle_cycles(input int n);
    rst = 1'b0; ram_read_en = 1'b0; ram_write_en = 1'b0; io_ready = 1'b0;
    ram_address_in = 16'h0000; ram_data_in = 16'h0000;
    repeat (n) @(posedge clk);
    mdl_cyc = mdl_cyc + 16'(n);
    #1;
  endtask

  initial begin
    logic [15:0] v1, v2, v3, addr, data;
    int op;
    mdl_out = 16'hxxxx;
    mdl_ovf = 1'b0;
    mdl_cyc = 16'h0000;

    // Reset
    applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("reset_out", ram_data_out, 16'h0000);
    chk("reset_valid", {15'b0, io_valid}, 16'h0000);
    idle_step(1'b0);

    // Preload a small RAM window and the neighbour of the test address
    for (int k = 0; k < 16; k++) wr(16'(k), 16'($urandom));
    wr(16'h0101, 16'h5A5A);

    wr(16'h0100, 16'h1234);
    rd(16'h0100);
    chk("ram_rw", ram_data_out, 16'h1234);
    rd(16'h0101);
    chk("ram_unwritten", ram_data_out, 16'h5A5A);
    idle_step(1'b0);
    chk("ram_hold", ram_data_out, 16'h5A5A);

    // Aliasing and I/O push-register read
    wr(16'h1005, 16'hBEEF);
    rd(16'h0005);
    chk("alias", ram_data_out, 16'hBEEF);
    rd(16'hFF00);
    chk("io_ff00_read", ram_data_out, 16'h0000);

    // Fill, overflow, clear
    for (int i = 1; i <= 8; i++) wr(16'hFF00, 16'(i));
    rd(16'hFF01);
    chk("status_full", ram_data_out, 16'h4008);
    wr(16'hFF00, 16'h0009);
    rd(16'hFF01);
    chk("status_ovf", ram_data_out, 16'hC008);
    wr(16'hFF01, 16'h8000);
    rd(16'hFF01);
    chk("status_clr", ram_data_out, 16'h4008);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", io_data, 16'(i));
      idle_step(1'b1);
    end
    chk("drain_valid", {15'b0, io_valid}, 16'h0000);
    rd(16'hFF01);
    chk("status_empty", ram_data_out, 16'h2000);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 8; i++) wr(16'hFF00, 16'(16'h0010 + i));
    applyStimulus(1'b0, 16'hFF00, 16'h00AA, 1'b0, 1'b1, 1'b1);
    rd(16'hFF01);
    chk("status_pushpop", ram_data_out, 16'h4008);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("aa_last", io_data, 16'h00AA);
      idle_step(1'b1);
    end

    // Cycle counter spacing and wrap
    rd(16'hFF02);
    v1 = ram_data_out;
    repeat (4) idle_step(1'b0);
    rd(16'hFF02);
    v2 = ram_data_out;
    chk("cyc_diff5", v2 - v1, 16'h0005);
    idle_cycles(65535);
    rd(16'hFF02);
    v3 = ram_data_out;
    chk("cyc_wrap", v3, v2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 9);
      data = 16'($urandom);
      addr = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom_range(0, 15))};
      case (op)
        0, 1: applyStimulus(1'b0, addr, data, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        2, 3: applyStimulus(1'b0, addr, data, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        4:    applyStimulus(1'b0, 16'hFF00, data, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        5:    applyStimulus(1'b0, 16'hFF01, data, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        6:    applyStimulus(1'b0, 16'hFF02, data, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        7:    applyStimulus(1'b0, 16'hFF01, data, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        8:    applyStimulus(1'b0, ($urandom_range(0, 1) != 0) ? addr : 16'hFF00, data,
                            1'b1, 1'b1, 1'($urandom_range(0, 1)));
        default: applyStimulus(1'b0, {8'hFF, 8'($urandom_range(3, 255))}, data,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
      endcase
    end

    // Reset in the middle of a drain, with a push strobe present
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(16'h0100 + i));
    idle_step(1'b1);
    applyStimulus(1'b1, 16'hFF00, 16'h7777, 1'b0, 1'b1, 1'b1);
    idle_step(1'b0);
    chk("rst_valid", {15'b0, io_valid}, 16'h0000);
    rd(16'hFF01);
    chk("rst_status", ram_data_out, 16'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
